phy_tx_symbol_scheduler: RTL and testbench

//  Sequences the 8-bit symbol + K-flag stream into the 8b/10b encoder (i_8b, K).

---
 rtl/phy_tx_pkg.sv | 24 ++
 rtl/phy_os_rom.sv | 38 +++
 rtl/phy_tx_symbol_scheduler.sv | 173 +++++++++++++++++
 tb/tb_phy_tx_symbol_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared constants and types for the TX PHY symbol scheduler.
package phy_tx_pkg;

    localparam logic [7:0] K_COM    = 8'hBC;
    localparam logic [7:0] K_SKP    = 8'h1C;
    localparam logic [7:0] K_PAD    = 8'hF7;
    localparam logic [7:0] D_TS1_ID = 8'h4A;
    localparam logic [7:0] D_IDLE   = 8'h00;
    localparam int         TS1_LEN  = 16;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        SKP,
        TS
    } state_t;

    // Selects which ordered-set table the ROM reads.
    typedef enum logic {
        OS_SKP,
        OS_TS1
    } os_t;

endpackage

// File: rtl/phy_os_rom.sv
// Ordered-set symbol tables: (os_type, index) -> {K, symbol}, plus a flag
// marking the final symbol of the selected ordered set.
module phy_os_rom
    import phy_tx_pkg::*;
#(
    parameter int SKP_LEN = 3
) (
    input  os_t        os_type,
    input  logic [3:0] idx,
    output logic       k,
    output logic [7:0] sym,
    output logic       last
);

    // Table lookup; index 0 of both sets is COM.
    always_comb begin
        k    = 1'b0;
        sym  = D_IDLE;
        last = 1'b0;
        if (os_type == OS_SKP) begin
            k    = 1'b1;
            sym  = (idx == 4'd0) ? K_COM : K_SKP;
            last = (idx == 4'(SKP_LEN));
        end else begin
            last = (idx == 4'(TS1_LEN - 1));
            case (idx)
                4'd0:    begin sym = K_COM; k = 1'b1; end
                4'd1,
                4'd2:    begin sym = K_PAD; k = 1'b1; end
                4'd3:    sym = 8'h00;
                4'd4:    sym = 8'h02;
                4'd5:    sym = 8'h00;
                default: sym = D_TS1_ID;
            endcase
        end
    end

endmodule

// File: rtl/phy_tx_symbol_scheduler.sv
// TX PHY symbol scheduler: merges link-layer data, TS1 ordered sets and
// periodic SKP ordered sets into one registered symbol stream for the
// 8b/10b encoder. SKP insertion is compiled in only when the macro
// PHY_SKP_INSERT_EN is defined; otherwise arbitration is TS1 > data > idle.
module phy_tx_symbol_scheduler
    import phy_tx_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       data_k_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       ts_req,
    output logic [7:0] i_8b,
    output logic       K,
    output logic       sym_valid,
    output logic       ts_done,
    output logic       skp_sent
);

    if (SKP_INTERVAL < 32) begin : g_bad_interval
        $error("SKP_INTERVAL must be at least 32");
    end
    if (SKP_LEN < 1 || SKP_LEN > 4) begin : g_bad_skp_len
        $error("SKP_LEN must be in 1..4");
    end

    state_t     state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic       ts_pending;
    logic       skp_pending;
    logic       ts_issue;

    logic [7:0] sym_nxt;
    logic       k_nxt, vld_nxt, ts_done_nxt, skp_sent_nxt;

    os_t        rom_type;
    logic       rom_k, rom_last;
    logic [7:0] rom_sym;

    // The ROM only serves ordered sets already in progress; the opening COM
    // is emitted directly so ROM inputs depend on registers alone.
    assign rom_type = (state == SKP) ? OS_SKP : OS_TS1;

    phy_os_rom #(.SKP_LEN(SKP_LEN)) u_rom (
        .os_type (rom_type),
        .idx     (idx),
        .k       (rom_k),
        .sym     (rom_sym),
        .last    (rom_last)
    );

    // Data is refused whenever the next slot belongs to an ordered set.
    assign data_ready = enable & reset_L & (state != SKP) & (state != TS)
                      & ~skp_pending & ~ts_pending;

`ifdef PHY_SKP_INSERT_EN
    localparam int CW = $clog2(SKP_INTERVAL);

    logic [CW-1:0] interval_cnt;
    logic          skp_issue;

    // Interval counter; a wrap while SKP is still pending is absorbed.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            interval_cnt <= '0;
            skp_pending  <= 1'b0;
        end else if (enable) begin
            if (interval_cnt == CW'(SKP_INTERVAL - 1)) begin
                interval_cnt <= '0;
                skp_pending  <= 1'b1;
            end else begin
                interval_cnt <= interval_cnt + 1'b1;
                if (skp_issue) skp_pending <= 1'b0;
            end
        end
    end
`else
    assign skp_pending = 1'b0;
`endif

    // Next-symbol selection: finish an ordered set in progress, otherwise
    // arbitrate SKP > TS1 > data > idle for the next slot.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        sym_nxt      = D_IDLE;
        k_nxt        = 1'b0;
        vld_nxt      = 1'b0;
        ts_done_nxt  = 1'b0;
        skp_sent_nxt = 1'b0;
        ts_issue     = 1'b0;
`ifdef PHY_SKP_INSERT_EN
        skp_issue    = 1'b0;
`endif
        if (enable) begin
            if (state == SKP || state == TS) begin
                sym_nxt = rom_sym;
                k_nxt   = rom_k;
                vld_nxt = 1'b1;
                if (rom_last) begin
                    state_nxt   = IDLE;
                    idx_nxt     = 4'd0;
                    ts_done_nxt = (state == TS);
`ifdef PHY_SKP_INSERT_EN
                    skp_sent_nxt = (state == SKP);
`endif
                end else begin
                    idx_nxt = idx + 4'd1;
                end
            end else begin
`ifdef PHY_SKP_INSERT_EN
                if (skp_pending) begin
                    sym_nxt   = K_COM;
                    k_nxt     = 1'b1;
                    vld_nxt   = 1'b1;
                    state_nxt = SKP;
                    idx_nxt   = 4'd1;
                    skp_issue = 1'b1;
                end else
`endif
                if (ts_pending) begin
                    sym_nxt   = K_COM;
                    k_nxt     = 1'b1;
                    vld_nxt   = 1'b1;
                    state_nxt = TS;
                    idx_nxt   = 4'd1;
                    ts_issue  = 1'b1;
                end else if (data_valid) begin
                    sym_nxt   = data_in;
                    k_nxt     = data_k_in;
                    vld_nxt   = 1'b1;
                    state_nxt = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    // State, TS1 request latch and registered encoder outputs. With enable
    // low the next-state logic holds state/idx and the outputs drop to idle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= IDLE;
            idx        <= 4'd0;
            ts_pending <= 1'b0;
            i_8b       <= D_IDLE;
            K          <= 1'b0;
            sym_valid  <= 1'b0;
            ts_done    <= 1'b0;
            skp_sent   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            i_8b       <= sym_nxt;
            K          <= k_nxt;
            sym_valid  <= vld_nxt;
            ts_done    <= ts_done_nxt;
            skp_sent   <= skp_sent_nxt;
            if (ts_issue)
                ts_pending <= 1'b0;
            else if (ts_req && state != TS)
                ts_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phy_tx_symbol_scheduler.sv
// Directed bench for phy_tx_symbol_scheduler: a per-cycle vector table plus
// hand-written sequences for continuous data with SKP and SKP/TS1 collision.
module tb_phy_tx_symbol_scheduler;
    import phy_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset_l, enable, data_k_in, data_valid, ts_req;
    logic [7:0] data_in;
    logic       data_ready, K, sym_valid, ts_done, skp_sent;
    logic [7:0] i_8b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst, en, dv;
        logic [7:0] d;
        logic       dk, tsr;
        logic       rdy;
        logic [7:0] sym;
        logic       k, vld, td, ss;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] ts_s [16] = '{8'hBC, 8'hF7, 8'hF7, 8'h00, 8'h02, 8'h00,
                              8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A,
                              8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    logic       ts_k [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [7:0] sent_q[$];
    logic [7:0] nxt, exp_s;
    logic       acc, exp_k;
    int         last_com, n_com, sidx;

    always #5 clk = ~clk;

    phy_tx_symbol_scheduler #(.SKP_INTERVAL(32), .SKP_LEN(3)) dut (
        .clk        (clk),
        .reset_L    (reset_l),
        .enable     (enable),
        .data_in    (data_in),
        .data_k_in  (data_k_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ts_req     (ts_req),
        .i_8b       (i_8b),
        .K          (K),
        .sym_valid  (sym_valid),
        .ts_done    (ts_done),
        .skp_sent   (skp_sent)
    );

    task automatic chk8(input string name, input int at, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %02h, want %02h", name, at, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int at, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b, want %b", name, at, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int rst, en, dv, d, dk, tsr, rdy, sym, k, vld, td, ss);
        vec_t v;
        v.rst = 1'(rst); v.en = 1'(en); v.dv = 1'(dv); v.d = 8'(d);
        v.dk = 1'(dk); v.tsr = 1'(tsr); v.rdy = 1'(rdy); v.sym = 8'(sym);
        v.k = 1'(k); v.vld = 1'(vld); v.td = 1'(td); v.ss = 1'(ss);
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset_l = 1'b0; enable = 1'b1; data_valid = 1'b0;
        data_in = 8'h00; data_k_in = 1'b0; ts_req = 1'b0;
        cyc();
        cyc();
        reset_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ------------------------------------------------------------ table
        //  rst en dv data  dk tsr | rdy sym   k vld td ss
        add(0, 1, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 0);   // reset held
        add(0, 1, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 0);
        add(1, 1, 0, 'h00, 0, 0,   1, 'h00, 0, 0, 0, 0);   // released, idle
        add(1, 1, 1, 'h21, 0, 0,   1, 'h21, 0, 1, 0, 0);   // data stream
        add(1, 1, 1, 'h4A, 0, 0,   1, 'h4A, 0, 1, 0, 0);
        add(1, 1, 1, 'h5C, 1, 0,   1, 'h5C, 1, 1, 0, 0);
        add(1, 1, 0, 'h00, 0, 0,   1, 'h00, 0, 0, 0, 0);   // idle filler
        add(1, 1, 1, 'h33, 0, 1,   1, 'h33, 0, 1, 0, 0);   // ts_req mid-data
        for (int i = 0; i < 16; i++)                        // TS1, data held off
            add(1, 1, 1, 'h44, 0, (i == 4) ? 1 : 0,          // ts_req inside TS ignored
                0, ts_s[i], ts_k[i], 1, (i == 15) ? 1 : 0, 0);
        add(1, 1, 1, 'h44, 0, 0,   1, 'h44, 0, 1, 0, 0);   // held data goes out
        add(1, 1, 0, 'h00, 0, 0,   1, 'h00, 0, 0, 0, 0);
        add(0, 1, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 0);   // fresh reset
        add(1, 1, 0, 'h00, 0, 1,   1, 'h00, 0, 0, 0, 0);   // ts_req from idle
        add(1, 1, 0, 'h00, 0, 0,   0, 'hBC, 1, 1, 0, 0);
        add(1, 1, 0, 'h00, 0, 0,   0, 'hF7, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++)                         // pause mid-TS1
            add(1, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 0);
        for (int i = 2; i <= 6; i++)                        // resume at index 2
            add(1, 1, 0, 'h00, 0, 0, 0, ts_s[i], ts_k[i], 1, 0, 0);
        add(0, 1, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 0);   // reset at symbol 7
        add(1, 1, 1, 'h55, 0, 0,   1, 'h55, 0, 1, 0, 0);   // TS1 not resumed
        add(1, 1, 0, 'h00, 0, 0,   1, 'h00, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            reset_l = vecs[i].rst; enable = vecs[i].en; data_valid = vecs[i].dv;
            data_in = vecs[i].d; data_k_in = vecs[i].dk; ts_req = vecs[i].tsr;
            #1;
            chk1("vec_data_ready", i, data_ready, vecs[i].rdy);
            cyc();
            chk8("vec_i_8b", i, i_8b, vecs[i].sym);
            chk1("vec_K", i, K, vecs[i].k);
            chk1("vec_sym_valid", i, sym_valid, vecs[i].vld);
            chk1("vec_ts_done", i, ts_done, vecs[i].td);
            chk1("vec_skp_sent", i, skp_sent, vecs[i].ss);
        end

        // ---------------------------------- continuous data, SKP every 32
        do_reset();
        nxt = 8'h01; last_com = 0; n_com = 0; sidx = 0;
        for (int c = 1; c <= 140; c++) begin
            data_valid = 1'b1; data_in = nxt; data_k_in = 1'b0;
            #1;
            acc = data_ready;
            if (acc) begin
                sent_q.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            cyc();
            chk1("cont_sym_valid", c, sym_valid, 1'b1);
            if (!K) begin
                exp_s = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
                chk8("cont_data", c, i_8b, exp_s);
            end
`ifdef PHY_SKP_INSERT_EN
            else if (i_8b == K_COM) begin
                chk8("skp_com_spacing", c, 8'(c - last_com), (n_com == 0) ? 8'd33 : 8'd32);
                last_com = c; n_com++; sidx = 0;
            end else begin
                sidx++;
                chk8("skp_symbol", c, i_8b, K_SKP);
            end
            chk1("cont_skp_sent", c, skp_sent, K && i_8b == K_SKP && sidx == 3);
`else
            chk1("no_os_without_skp", c, K, 1'b0);
            chk1("skp_sent_tied", c, skp_sent, 1'b0);
`endif
        end
        chk8("cont_no_loss", 0, 8'(sent_q.size()), 8'd0);
`ifdef PHY_SKP_INSERT_EN
        chk8("skp_count", 0, 8'(n_com), 8'd4);

        // ------------------- ts_req on the SKP wrap cycle, pause in TS1
        do_reset();
        for (int c = 1; c <= 31; c++) cyc();
        ts_req = 1'b1;
        cyc();
        ts_req = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j == 10) begin
                enable = 1'b0;
                for (int p = 0; p < 5; p++) begin
                    #1;
                    chk1("pause_ready", p, data_ready, 1'b0);
                    cyc();
                    chk8("pause_i_8b", p, i_8b, 8'h00);
                    chk1("pause_valid", p, sym_valid, 1'b0);
                end
                enable = 1'b1;
            end
            if (j < 4) begin
                exp_s = (j == 0) ? K_COM : K_SKP;
                exp_k = 1'b1;
            end else begin
                exp_s = ts_s[j-4];
                exp_k = ts_k[j-4];
            end
            #1;
            chk1("bb_ready", j, data_ready, 1'b0);
            cyc();
            chk8("bb_i_8b", j, i_8b, exp_s);
            chk1("bb_K", j, K, exp_k);
            chk1("bb_valid", j, sym_valid, 1'b1);
            chk1("bb_skp_sent", j, skp_sent, j == 3);
            chk1("bb_ts_done", j, ts_done, j == 19);
        end
        cyc();
        chk1("bb_idle_after", 0, sym_valid, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
